rotate_addr_gen: RTL and testbench

- Parametrised successor to the fixed 90-degree small-image rotator.
- Maps a raster coordinate stream (hcount/vcount) to a read address into a row-major frame buffer for any of four rotations plus horizontal mirror.
- Pixel data and valid flag are pipelined alongside the address.
- Sits between the video timing / pixel source and the frame-buffer BRAM port. Mode changes are applied only at frame boundaries so frames never tear.

---
 rtl/rotate_pkg.sv | 18 +
 rtl/rotate_coord_map.sv | 69 ++++++
 rtl/rotate_addr_gen.sv | 132 +++++++++++++
 tb/tb_rotate_addr_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotating frame-buffer address generator.
package rotate_pkg;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_mode_t;

  typedef struct packed {
    logic      mirror;
    rot_mode_t rot;
  } mode_t;

  localparam int unsigned PIPE_LATENCY = 3;

endpackage

// File: rtl/rotate_coord_map.sv
// Combinational operand selector: maps a raster coordinate and mode to
// row term, row stride and column term so that address = row*stride + col.
module rotate_coord_map
  import rotate_pkg::*;
#(
  parameter int unsigned IN_W     = 107,
  parameter int unsigned IN_H     = 80,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned HCOUNT_W = 11,
  parameter int unsigned VCOUNT_W = 10
) (
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  mode_t               mode,
  output logic                in_range,
  output logic [ADDR_W-1:0]   row,
  output logic [ADDR_W-1:0]   stride,
  output logic [ADDR_W-1:0]   col
);

  localparam logic [ADDR_W-1:0] W_MAX = ADDR_W'(IN_W - 1);
  localparam logic [ADDR_W-1:0] H_MAX = ADDR_W'(IN_H - 1);
  localparam logic [ADDR_W-1:0] W_K   = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] H_K   = ADDR_W'(IN_H);

  logic [ADDR_W-1:0] h_a;
  logic [ADDR_W-1:0] v_a;
  logic [ADDR_W-1:0] h_m;

  assign in_range = (32'(hcount) < IN_W) && (32'(vcount) < IN_H);

  // Out-of-range coordinates skip the subtractions entirely and yield zeros.
  always_comb begin
    h_a    = '0;
    v_a    = '0;
    h_m    = '0;
    row    = '0;
    col    = '0;
    stride = (mode.rot == ROT_90 || mode.rot == ROT_270) ? H_K : W_K;
    if (in_range) begin
      h_a = ADDR_W'(hcount);
      v_a = ADDR_W'(vcount);
      h_m = mode.mirror ? (W_MAX - h_a) : h_a;
      unique case (mode.rot)
        ROT_0: begin
          row = v_a;
          col = h_m;
        end
        ROT_90: begin
          row = W_MAX - h_m;
          col = v_a;
        end
        ROT_180: begin
          row = H_MAX - v_a;
          col = W_MAX - h_m;
        end
        ROT_270: begin
          row = h_m;
          col = H_MAX - v_a;
        end
        default: begin
          row = '0;
          col = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rotate_addr_gen.sv
// Three-stage raster-to-frame-buffer address generator with rotation/mirror,
// mode latched only at frame start so frames never tear.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int unsigned IN_W     = 107,
  parameter int unsigned IN_H     = 80,
  parameter int unsigned PIXEL_W  = 1,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned HCOUNT_W = 11,
  parameter int unsigned VCOUNT_W = 10
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                data_valid_in,
  input  logic [PIXEL_W-1:0]  pixel_in,
  input  logic [1:0]          rot_mode_in,
  input  logic                mirror_in,
  output logic [PIXEL_W-1:0]  pixel_out,
  output logic [ADDR_W-1:0]   pixel_addr_out,
  output logic                data_valid_out,
  output logic                in_range_out,
  output logic                frame_start_out,
  output logic [2:0]          active_mode_out
);

  if (longint'(IN_W) * longint'(IN_H) > (64'd1 << ADDR_W)) begin : g_addr_w_check
    $error("rotate_addr_gen: ADDR_W too small for IN_W*IN_H");
  end

  mode_t             active_mode;
  mode_t             mode_next;
  logic              frame_start;
  logic              map_range;
  logic [ADDR_W-1:0] map_row;
  logic [ADDR_W-1:0] map_stride;
  logic [ADDR_W-1:0] map_col;

  logic [ADDR_W-1:0]  s1_row;
  logic [ADDR_W-1:0]  s1_stride;
  logic [ADDR_W-1:0]  s1_col;
  logic               s1_valid;
  logic               s1_range;
  logic               s1_fs;
  logic [PIXEL_W-1:0] s1_pix;

  logic [ADDR_W-1:0]  s2_prod;
  logic [ADDR_W-1:0]  s2_col;
  logic               s2_valid;
  logic               s2_range;
  logic               s2_fs;
  logic [PIXEL_W-1:0] s2_pix;

  assign frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);

  // Stage 1 sees the mode being loaded on this edge, so a frame's first pixel uses it.
  always_comb begin
    mode_next = active_mode;
    if (frame_start) begin
      mode_next.mirror = mirror_in;
      mode_next.rot    = rot_mode_t'(rot_mode_in);
    end
  end

  rotate_coord_map #(
    .IN_W     (IN_W),
    .IN_H     (IN_H),
    .ADDR_W   (ADDR_W),
    .HCOUNT_W (HCOUNT_W),
    .VCOUNT_W (VCOUNT_W)
  ) u_map (
    .hcount   (hcount_in),
    .vcount   (vcount_in),
    .mode     (mode_next),
    .in_range (map_range),
    .row      (map_row),
    .stride   (map_stride),
    .col      (map_col)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_mode     <= '0;
      s1_row          <= '0;
      s1_stride       <= '0;
      s1_col          <= '0;
      s1_valid        <= 1'b0;
      s1_range        <= 1'b0;
      s1_fs           <= 1'b0;
      s1_pix          <= '0;
      s2_prod         <= '0;
      s2_col          <= '0;
      s2_valid        <= 1'b0;
      s2_range        <= 1'b0;
      s2_fs           <= 1'b0;
      s2_pix          <= '0;
      pixel_addr_out  <= '0;
      pixel_out       <= '0;
      data_valid_out  <= 1'b0;
      in_range_out    <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      active_mode     <= mode_next;

      s1_row          <= map_row;
      s1_stride       <= map_stride;
      s1_col          <= map_col;
      s1_valid        <= data_valid_in;
      s1_range        <= data_valid_in && map_range;
      s1_fs           <= frame_start;
      s1_pix          <= pixel_in;

      s2_prod         <= s1_row * s1_stride;
      s2_col          <= s1_col;
      s2_valid        <= s1_valid;
      s2_range        <= s1_range;
      s2_fs           <= s1_fs;
      s2_pix          <= s1_pix;

      pixel_addr_out  <= s2_prod + s2_col;
      pixel_out       <= s2_pix;
      data_valid_out  <= s2_valid;
      in_range_out    <= s2_range;
      frame_start_out <= s2_fs;
    end
  end

  assign active_mode_out = active_mode;

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Randomized self-checking bench for rotate_addr_gen against a geometric
// quarter-turn reference model.
module tb_rotate_addr_gen;
  import rotate_pkg::*;

  localparam int unsigned IN_W     = 107;
  localparam int unsigned IN_H     = 80;
  localparam int unsigned PIXEL_W  = 1;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  logic                clk_in = 1'b0;
  logic                rst_n_in;
  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                data_valid_in;
  logic [PIXEL_W-1:0]  pixel_in;
  logic [1:0]          rot_mode_in;
  logic                mirror_in;
  logic [PIXEL_W-1:0]  pixel_out;
  logic [ADDR_W-1:0]   pixel_addr_out;
  logic                data_valid_out;
  logic                in_range_out;
  logic                frame_start_out;
  logic [2:0]          active_mode_out;

  always #5 clk_in = ~clk_in;

  rotate_addr_gen #(
    .IN_W     (IN_W),
    .IN_H     (IN_H),
    .PIXEL_W  (PIXEL_W),
    .ADDR_W   (ADDR_W),
    .HCOUNT_W (HCOUNT_W),
    .VCOUNT_W (VCOUNT_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .data_valid_in   (data_valid_in),
    .pixel_in        (pixel_in),
    .rot_mode_in     (rot_mode_in),
    .mirror_in       (mirror_in),
    .pixel_out       (pixel_out),
    .pixel_addr_out  (pixel_addr_out),
    .data_valid_out  (data_valid_out),
    .in_range_out    (in_range_out),
    .frame_start_out (frame_start_out),
    .active_mode_out (active_mode_out)
  );

  typedef struct {
    bit          v;
    bit          rng;
    bit          fs;
    int unsigned addr;
    int unsigned pix;
  } exp_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned m_rot;
  bit          m_mir;
  exp_t        hist[PIPE_LATENCY];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Rotate the (mirrored) point clockwise one quarter-turn at a time and
  // read off its row-major position in the rotated image.
  function automatic int unsigned ref_addr(int unsigned h, int unsigned v,
                                           int unsigned rot, bit mir);
    int unsigned row, col, width, height, nr, nc;
    if (h >= IN_W || v >= IN_H) return 0;
    col    = mir ? (IN_W - 1 - h) : h;
    row    = v;
    width  = IN_W;
    height = IN_H;
    for (int unsigned q = 0; q < rot; q++) begin
      nr     = width - 1 - col;
      nc     = row;
      row    = nr;
      col    = nc;
      nr     = width;
      width  = height;
      height = nr;
    end
    return row * width + col;
  endfunction

  task automatic model_clear();
    m_rot = 0;
    m_mir = 1'b0;
    for (int i = 0; i < int'(PIPE_LATENCY); i++) hist[i] = '{0, 0, 0, 0, 0};
  endtask

  task automatic compare_out(input exp_t e);
    check_eq("valid", 32'(data_valid_out), 32'(e.v));
    check_eq("in_range", 32'(in_range_out), 32'(e.rng));
    check_eq("frame_start", 32'(frame_start_out), 32'(e.fs));
    check_eq("active_mode", 32'(active_mode_out), 32'({m_mir, 2'(m_rot)}));
    if (e.v) begin
      check_eq("addr", 32'(pixel_addr_out), e.addr);
      check_eq("pixel", 32'(pixel_out), e.pix);
    end
  endtask

  task automatic drive(input int unsigned h, input int unsigned v, input bit valid,
                       input bit pix, input int unsigned rot, input bit mir);
    exp_t e;
    hcount_in     = HCOUNT_W'(h);
    vcount_in     = VCOUNT_W'(v);
    data_valid_in = valid;
    pixel_in      = PIXEL_W'(pix);
    rot_mode_in   = 2'(rot);
    mirror_in     = mir;
    @(posedge clk_in);
    if (valid && h == 0 && v == 0) begin
      m_rot = rot;
      m_mir = mir;
    end
    e.v    = valid;
    e.rng  = valid && (h < IN_W) && (v < IN_H);
    e.fs   = valid && (h == 0) && (v == 0);
    e.addr = ref_addr(h, v, m_rot, m_mir);
    e.pix  = pix;
    for (int i = int'(PIPE_LATENCY) - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = e;
    #1;
    compare_out(hist[PIPE_LATENCY-1]);
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(data_valid_out), 0);
    check_eq({tag, "_range"}, 32'(in_range_out), 0);
    check_eq({tag, "_fs"}, 32'(frame_start_out), 0);
    check_eq({tag, "_addr"}, 32'(pixel_addr_out), 0);
    check_eq({tag, "_mode"}, 32'(active_mode_out), 0);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    hcount_in     = '0;
    vcount_in     = '0;
    data_valid_in = 1'b0;
    pixel_in      = '0;
    rot_mode_in   = '0;
    mirror_in     = 1'b0;
    model_clear();
    #12;
    check_zero_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // 90 deg frame start then next pixel
    drive(0, 0, 1'b1, 1'b1, 1, 1'b0);
    drive(1, 0, 1'b1, 1'b0, 1, 1'b0);
    idle();
    check_eq("rot90_first_addr", 32'(pixel_addr_out), 8480);
    check_eq("rot90_first_fs", 32'(frame_start_out), 1);
    idle();
    check_eq("rot90_second_addr", 32'(pixel_addr_out), 8400);
    check_eq("rot90_second_fs", 32'(frame_start_out), 0);

    // 0 deg, then mid-frame mode change ignored
    drive(0, 0, 1'b1, 1'b0, 0, 1'b0);
    drive(5, 2, 1'b1, 1'b1, 0, 1'b0);
    drive(5, 2, 1'b1, 1'b1, 2, 1'b0);
    idle();
    check_eq("rot0_addr", 32'(pixel_addr_out), 219);
    idle();
    check_eq("midframe_ignored_addr", 32'(pixel_addr_out), 219);

    drive(0, 0, 1'b1, 1'b0, 2, 1'b0);
    idle();
    idle();
    check_eq("rot180_addr", 32'(pixel_addr_out), 8559);
    check_eq("rot180_mode", 32'(active_mode_out), 2);

    drive(0, 0, 1'b1, 1'b0, 3, 1'b0);
    drive(10, 0, 1'b1, 1'b0, 3, 1'b0);
    idle();
    idle();
    check_eq("rot270_addr", 32'(pixel_addr_out), 879);

    drive(0, 0, 1'b1, 1'b0, 0, 1'b1);
    idle();
    idle();
    check_eq("mirror_addr", 32'(pixel_addr_out), 106);

    // Out of range and invalid
    drive(107, 3, 1'b1, 1'b1, 0, 1'b0);
    drive(4, 4, 1'b0, 1'b0, 0, 1'b0);
    idle();
    check_eq("oor_range", 32'(in_range_out), 0);
    check_eq("oor_addr", 32'(pixel_addr_out), 0);
    check_eq("oor_valid", 32'(data_valid_out), 1);
    idle();
    check_eq("invalid_valid", 32'(data_valid_out), 0);

    // Full row at 90 deg, v=7
    drive(0, 0, 1'b1, 1'b0, 1, 1'b0);
    for (int unsigned h = 0; h < IN_W; h++)
      drive(h, 7, 1'b1, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    idle();
    idle();

    // Random frames
    for (int f = 0; f < 8; f++) begin
      drive(0, 0, 1'b1, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
      for (int n = 0; n < 80; n++)
        drive($urandom_range(0, IN_W + 4), $urandom_range(0, IN_H + 2),
              $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 3), 1'($urandom));
    end

    // Reset with two valids in flight
    drive(0, 0, 1'b1, 1'b1, 3, 1'b1);
    drive(20, 30, 1'b1, 1'b1, 0, 1'b0);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_clear();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int n = 0; n < 4; n++) idle();
    drive(30, 40, 1'b1, 1'b1, 2, 1'b1);
    for (int n = 0; n < 3; n++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
